keccak_pad_sequencer: RTL and testbench
=======================================

Name: keccak_pad_sequencer

Overview:
- Sequences message words into full Keccak rate blocks for the Keccak512 permutation core.
- Accepts a word stream over a valid/ready handshake and applies byte-granular 0x01 pad on the final word, identical in encoding to padder1.
- Zero-fills the rest of the block and sets the 0x80 final pad bit in the last word.
- Presents each completed block to the permutation and holds it until acknowledged.

Parameters:
- IW, 64, input word width in bits; only 64 and 128 supported.
- RATE_WORDS, 9, words per rate block (9 x 64 = 576 for Keccak512).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  IW  message word; byte 0 is the MSB byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies the final word of a message.
- in_bytes  input  4  valid byte count of the final word, 0..IW/8-1; read only when in_last=1.
- in_ready  output  1  block accepts a word this cycle.
- blk_data  output  IW*RATE_WORDS  rate block; first word at the MSBs.
- blk_valid  output  1  blk_data holds a complete block.
- blk_last  output  1  the held block is the final block of the message.
- blk_ack  input  1  permutation consumed the block.

Behaviour:
- Reset (async, rst_n=0):
  - State FILL, word count 0.
  - blk_data=0, blk_valid=0, blk_last=0.
  - Any partial message is discarded.
- Encoding: a full final word (IW/8 bytes) is sent as a non-last word, followed by a last word with in_bytes=0.
- in_bytes is interpreted modulo IW/8: low 3 bits for IW=64, all 4 bits for IW=128.
- Pad word: bytes 0..n-1 come from in_data, byte n=0x01, remaining bytes zero (n=in_bytes). Same as padder1.
- Word shift: every accepted or generated word shifts into blk_data from the LSB end, buffer <= {buffer[IW*(RATE_WORDS-1)-1:0], w}.
- Final-bit rule: when the word count is RATE_WORDS-1 and the block is the final block, the word is ORed with 0x80 in bits [7:0]. Pad byte in the same word with n=IW/8-1 yields 0x81.
- in_ready = (state==FILL). It is combinational from state only and never depends on in_valid.
- FILL: on in_valid&in_ready, shift in the word and increment count.
  - in_last=0 and count==RATE_WORDS-1: go to FULL with blk_last=0.
  - in_last=1 and count==RATE_WORDS-1: shift in the pad word with 0x80, go to FULL with blk_last=1. No PAD cycles.
  - in_last=1 and count<RATE_WORDS-1: shift in the pad word, go to PAD.
- PAD: in_ready=0. Each cycle shift in a zero word, or 0x80 at count RATE_WORDS-1. On the final word go to FULL with blk_last=1. PAD lasts RATE_WORDS-1-count_at_entry cycles.
- FULL: blk_valid=1, and blk_data and blk_last are held stable.
  - On blk_ack: next cycle count=0, state=FILL, blk_valid=0, blk_last=0.
  - blk_data is retained and need not be cleared.
- Latency: blk_valid rises on the cycle after the last buffer write.
  - Last word accepted at edge k gives blk_valid high after edge k when no padding is needed.
  - Otherwise blk_valid is high after edge k+(RATE_WORDS-1-count).
- Ignored inputs:
  - blk_ack is ignored when blk_valid=0.
  - in_valid is ignored in PAD and FULL.
  - in_last and in_bytes are ignored when the handshake does not complete.
- No bubble is required between blocks of one message. Words for the next block are accepted from the cycle after blk_ack.
- Reset asserted in any state forces the reset values immediately (async). Operation restarts in FILL on the first edge after rst_n deasserts.
- Parameter guard: IW not 64 or 128 triggers a $display and $finish under SIMULATION.

Test Plan:
1. Empty message: one word, in_last=1, in_bytes=0.
   - PAD runs for 8 cycles, then blk_valid=1 and blk_last=1.
   - word0=0x0100000000000000, words1-7=0, word8=0x0000000000000080.
2. "abc": in_data=0x616263FFFFFFFFFF, in_last=1, in_bytes=3.
   - word0=0x6162630100000000.
   - word8=0x80; all other words 0.
3. Final word as block word 9: 8 full words, then a last word 0x1122334455667700 with in_bytes=7.
   - No PAD cycles; blk_valid on the next cycle.
   - word8=0x1122334455667781, blk_last=1.
4. Back-pressure on output: 9 non-last words, then hold blk_ack=0 for 5 cycles.
   - blk_valid=1, blk_last=0; in_ready=0 and blk_data stable throughout.
   - Pulse blk_ack: next cycle blk_valid=0 and in_ready=1.
5. Two-block message with gaps: 10 words with in_valid deasserted randomly, the 10th last with in_bytes=2.
   - Block 1 has blk_last=0.
   - Block 2: word0 = two data bytes then 0x01, word8=0x80, blk_last=1.
6. Reset mid-PAD: drop rst_n on PAD cycle 3.
   - Immediately blk_valid=0, blk_last=0, blk_data=0.
   - After release, the empty-message scenario reproduces result 1 exactly.

Source files
------------

// File: rtl/keccak_pad_sequencer.sv
// keccak_pad_sequencer
// Collects a stream of message words into full Keccak rate blocks. The final
// word of a message receives the byte-granular 0x01 pad; the remainder of the
// block is zero-filled and the last word of the final block carries 0x80 in
// its low byte. A completed block is held on blk_data until blk_ack.

`default_nettype none

module keccak_pad_sequencer #(
    parameter int IW         = 64,
    parameter int RATE_WORDS = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IW-1:0]              in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [3:0]                 in_bytes,
    output logic                       in_ready,
    output logic [IW*RATE_WORDS-1:0]   blk_data,
    output logic                       blk_valid,
    output logic                       blk_last,
    input  logic                       blk_ack
);

    localparam int         NBYTES = IW / 8;
    localparam int         CW     = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(RATE_WORDS - 1);
    // in_bytes is taken modulo the bytes per word (3 bits for 64, 4 for 128)
    localparam logic [3:0] BMASK  = 4'(NBYTES - 1);
    localparam logic [IW-1:0] FINAL_BIT = IW'(8'h80);

`ifdef SIMULATION
    initial begin
        if (IW != 64 && IW != 128) begin
            $display("keccak_pad_sequencer: unsupported IW=%0d (only 64 or 128)", IW);
            $finish;
        end
    end
`endif

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            last_nxt;
    logic            shift_en;
    logic [IW-1:0]   shift_word;
    logic [3:0]      pad_n;

    // Keep bytes 0..n-1 (byte 0 is the MSB byte), place 0x01 at byte n,
    // zero every byte after it.
    function automatic logic [IW-1:0] pad_word(input logic [IW-1:0] d,
                                               input logic [3:0]    n);
        logic [IW-1:0] w;
        w = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (b < int'(n))
                w[IW-1-8*b -: 8] = d[IW-1-8*b -: 8];
            else if (b == int'(n))
                w[IW-1-8*b -: 8] = 8'h01;
        end
        return w;
    endfunction

    assign pad_n     = in_bytes & BMASK;
    assign in_ready  = (state == FILL);
    assign blk_valid = (state == FULL);

    // Next-state, word-count and buffer-write selection
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        last_nxt   = blk_last;
        shift_en   = 1'b0;
        shift_word = '0;
        unique case (state)
            FILL: begin
                if (in_valid) begin
                    shift_en  = 1'b1;
                    count_nxt = count + 1'b1;
                    if (in_last) begin
                        shift_word = pad_word(in_data, pad_n);
                        if (count == LAST_CNT) begin
                            // Pad and final bit land in the same word
                            shift_word = shift_word | FINAL_BIT;
                            count_nxt  = count;
                            last_nxt   = 1'b1;
                            state_nxt  = FULL;
                        end else begin
                            state_nxt  = PAD;
                        end
                    end else begin
                        shift_word = in_data;
                        if (count == LAST_CNT) begin
                            count_nxt = count;
                            last_nxt  = 1'b0;
                            state_nxt = FULL;
                        end
                    end
                end
            end
            PAD: begin
                shift_en  = 1'b1;
                count_nxt = count + 1'b1;
                if (count == LAST_CNT) begin
                    shift_word = FINAL_BIT;
                    count_nxt  = count;
                    last_nxt   = 1'b1;
                    state_nxt  = FULL;
                end
            end
            FULL: begin
                if (blk_ack) begin
                    count_nxt = '0;
                    last_nxt  = 1'b0;
                    state_nxt = FILL;
                end
            end
            default: begin
                count_nxt = '0;
                last_nxt  = 1'b0;
                state_nxt = FILL;
            end
        endcase
    end

    // Control registers: state, word count, final-block flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            count    <= '0;
            blk_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            blk_last <= last_nxt;
        end
    end

    // Rate buffer: words enter at the LSB end, first word ends up at the MSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_data <= '0;
        end else if (shift_en) begin
            blk_data <= {blk_data[IW*(RATE_WORDS-1)-1:0], shift_word};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keccak_pad_sequencer.sv
// Directed bench for keccak_pad_sequencer (IW=64, RATE_WORDS=9).

`timescale 1ns/1ps

module tb_keccak_pad_sequencer;

    localparam int IW = 64;
    localparam int RW = 9;
    localparam int BW = IW * RW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          in_ready;
    logic [BW-1:0] blk_data;
    logic          blk_valid;
    logic          blk_last;
    logic          blk_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [IW-1:0] ew [RW];
    logic [BW-1:0] exp_blk;
    logic [BW-1:0] held;
    int            cyc;

    keccak_pad_sequencer #(.IW(IW), .RATE_WORDS(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .blk_ack   (blk_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] pack_words();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < RW; i++) b = {b[BW-IW-1:0], ew[i]};
        return b;
    endfunction

    task automatic clear_words();
        for (int i = 0; i < RW; i++) ew[i] = '0;
    endtask

    // Present one word and hold it until the handshake completes (bounded)
    task automatic send(input logic [IW-1:0] d, input logic l, input logic [3:0] nb);
        int t;
        in_data  = d;
        in_last  = l;
        in_bytes = nb;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout observed=%0d expected=%0d", in_ready, 1);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 4'd0;
    endtask

    // Count edges until blk_valid rises (bounded)
    task automatic wait_blk(output int c);
        c = 0;
        while (!blk_valid && c < 50) begin
            tick();
            c++;
        end
    endtask

    task automatic ack();
        blk_ack = 1'b1;
        tick();
        blk_ack = 1'b0;
        chk("ack_valid_low", BW'(blk_valid), BW'(1'b0));
        chk("ack_ready_high", BW'(in_ready), BW'(1'b1));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 4'd0;
        blk_ack  = 1'b0;
        tick();
        tick();
        chk("rst_valid", BW'(blk_valid), BW'(1'b0));
        chk("rst_last", BW'(blk_last), BW'(1'b0));
        chk("rst_data", blk_data, '0);
        chk("rst_ready", BW'(in_ready), BW'(1'b1));
        rst_n = 1'b1;
        tick();

        // 1. Empty message
        send(64'hDEADBEEFDEADBEEF, 1'b1, 4'd0);
        wait_blk(cyc);
        chk("t1_pad_cycles", BW'(cyc), BW'(8));
        clear_words();
        ew[0] = 64'h0100000000000000;
        ew[8] = 64'h0000000000000080;
        exp_blk = pack_words();
        chk("t1_data", blk_data, exp_blk);
        chk("t1_last", BW'(blk_last), BW'(1'b1));
        chk("t1_ready", BW'(in_ready), BW'(1'b0));
        ack();

        // 2. "abc"
        send(64'h616263FFFFFFFFFF, 1'b1, 4'd3);
        wait_blk(cyc);
        chk("t2_pad_cycles", BW'(cyc), BW'(8));
        clear_words();
        ew[0] = 64'h6162630100000000;
        ew[8] = 64'h0000000000000080;
        exp_blk = pack_words();
        chk("t2_data", blk_data, exp_blk);
        chk("t2_last", BW'(blk_last), BW'(1'b1));
        ack();

        // 3. Final word is block word 9, pad byte merges with final bit
        for (int i = 0; i < 8; i++) begin
            ew[i] = {8{8'(i + 1)}};
            send(ew[i], 1'b0, 4'd5);
        end
        send(64'h1122334455667700, 1'b1, 4'd7);
        chk("t3_no_pad", BW'(blk_valid), BW'(1'b1));
        ew[8] = 64'h1122334455667781;
        exp_blk = pack_words();
        chk("t3_data", blk_data, exp_blk);
        chk("t3_last", BW'(blk_last), BW'(1'b1));
        ack();

        // 4. Output back-pressure with in_valid held high
        for (int i = 0; i < RW; i++) begin
            ew[i] = 64'hA5A5000000000000 | 64'(i * 3 + 1);
            send(ew[i], 1'b0, 4'd0);
        end
        exp_blk = pack_words();
        held    = blk_data;
        chk("t4_data", blk_data, exp_blk);
        in_valid = 1'b1;
        in_data  = 64'hFFFFFFFFFFFFFFFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", BW'(blk_valid), BW'(1'b1));
            chk("t4_hold_last", BW'(blk_last), BW'(1'b0));
            chk("t4_hold_ready", BW'(in_ready), BW'(1'b0));
            chk("t4_hold_data", blk_data, held);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ack();

        // 5. Two-block message with idle gaps
        for (int i = 0; i < RW; i++) begin
            ew[i] = 64'h0123456789ABCDEF ^ 64'(i << 8);
            repeat ($urandom_range(0, 3)) tick();
            send(ew[i], 1'b0, 4'd0);
        end
        exp_blk = pack_words();
        chk("t5_b1_valid", BW'(blk_valid), BW'(1'b1));
        chk("t5_b1_data", blk_data, exp_blk);
        chk("t5_b1_last", BW'(blk_last), BW'(1'b0));
        ack();
        repeat ($urandom_range(1, 3)) tick();
        send(64'hABCDEF0011223344, 1'b1, 4'd2);
        wait_blk(cyc);
        chk("t5_pad_cycles", BW'(cyc), BW'(8));
        clear_words();
        ew[0] = 64'hABCD010000000000;
        ew[8] = 64'h0000000000000080;
        exp_blk = pack_words();
        chk("t5_b2_data", blk_data, exp_blk);
        chk("t5_b2_last", BW'(blk_last), BW'(1'b1));
        ack();

        // 6. Reset in the middle of PAD, then rerun the empty message
        send(64'h0, 1'b1, 4'd0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", BW'(blk_valid), BW'(1'b0));
        chk("t6_rst_last", BW'(blk_last), BW'(1'b0));
        chk("t6_rst_data", blk_data, '0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_ready", BW'(in_ready), BW'(1'b1));
        send(64'h0, 1'b1, 4'd0);
        wait_blk(cyc);
        chk("t6_pad_cycles", BW'(cyc), BW'(8));
        clear_words();
        ew[0] = 64'h0100000000000000;
        ew[8] = 64'h0000000000000080;
        exp_blk = pack_words();
        chk("t6_data", blk_data, exp_blk);
        chk("t6_last", BW'(blk_last), BW'(1'b1));
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
